// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store unit: byte-lane alignment, misalignment trap and response timeout.
// Define LSU_MISALIGNED_SPLIT_EN to split boundary-crossing accesses into two word transactions.
module lsu_mem_port #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [3:0]  o_mem_mask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RESP = 3'd3,
                              ISSUE2 = 3'd4, WAIT2 = 3'd5} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
`endif

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size, input logic uns);
        case (size)
            2'b00:   extend = uns ? {24'h000000, d[7:0]} : {{24{d[7]}}, d[7:0]};
            2'b01:   extend = uns ? {16'h0000, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    state_t                state_r, state_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  cnt_clr_s, busy_s, timeout_s, illegal_s, we_s;
    logic                  we_r, uns_r;
    logic [1:0]            size_r, off_r;
    logic [4:0]            shamt_s, rshamt_s;
    logic [3:0]            mask_lo_s, mem_mask_s;
    logic [31:0]           wdata_lo_s, mem_wdata_s, mem_addr_s;
    logic [31:0]           load_single_s, rsp_rdata_s;
    logic                  rsp_trap_s;

    assign shamt_s       = {i_req_addr[1:0], 3'b000};
    assign rshamt_s      = {off_r, 3'b000};
    assign mask_lo_s     = size_mask(i_req_size) << i_req_addr[1:0];
    assign wdata_lo_s    = i_req_wdata << shamt_s;
    assign load_single_s = extend(i_mem_rdata >> rshamt_s, size_r, uns_r);
    assign busy_s        = (state_r != IDLE) && (state_r != RESP);
    // cnt_r is one less than the cycles spent so far, so the trap response lands TIMEOUT_CYCLES after accept
    assign timeout_s     = (TIMEOUT_CYCLES != 0) && ((32'(cnt_r) + 32'd2) >= 32'(TIMEOUT_CYCLES));

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        split_s, split_r, capture_s;
    logic [3:0]  mask_hi_s, mask_hi_r;
    logic [31:0] wdata_hi_s, wdata_hi_r, rlo_r, load_split_s;

    assign illegal_s    = (i_req_size == 2'b11);
    assign mask_hi_s    = size_mask(i_req_size) >> (3'd4 - {1'b0, i_req_addr[1:0]});
    assign wdata_hi_s   = i_req_wdata >> (6'd32 - {1'b0, shamt_s});
    assign split_s      = (mask_hi_s != 4'b0000);
    assign load_split_s = extend((rlo_r >> rshamt_s) | (i_mem_rdata << (6'd32 - {1'b0, rshamt_s})),
                                 size_r, uns_r);
`else
    assign illegal_s = (i_req_size == 2'b11)
                     || ((i_req_size == 2'b01) && i_req_addr[0])
                     || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
`endif

    // Next-state, next memory-request fields and response value
    always_comb begin
        state_s     = state_r;
        cnt_clr_s   = 1'b0;
        rsp_trap_s  = 1'b0;
        rsp_rdata_s = 32'h00000000;
        mem_addr_s  = o_mem_addr;
        mem_mask_s  = o_mem_mask;
        mem_wdata_s = o_mem_wdata;
        we_s        = we_r;
`ifdef LSU_MISALIGNED_SPLIT_EN
        capture_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                we_s = i_req_we;
                if (i_req_valid) begin
                    cnt_clr_s = 1'b1;
                    if (illegal_s) begin
                        state_s    = RESP;
                        rsp_trap_s = 1'b1;
                    end else begin
                        state_s     = ISSUE;
                        mem_addr_s  = {i_req_addr[31:2], 2'b00};
                        mem_mask_s  = mask_lo_s;
                        mem_wdata_s = wdata_lo_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (i_mem_ready) begin
                    if (!we_r) begin
                        state_s = WAIT;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    end else if (split_r) begin
                        state_s     = ISSUE2;
                        cnt_clr_s   = 1'b1;
                        mem_addr_s  = o_mem_addr + 32'd4;
                        mem_mask_s  = mask_hi_r;
                        mem_wdata_s = wdata_hi_r;
`endif
                    end else begin
                        state_s = RESP;
                    end
                end else if (timeout_s) begin
                    state_s    = RESP;
                    rsp_trap_s = 1'b1;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (split_r) begin
                        state_s    = ISSUE2;
                        capture_s  = 1'b1;
                        cnt_clr_s  = 1'b1;
                        mem_addr_s = o_mem_addr + 32'd4;
                        mem_mask_s = mask_hi_r;
                    end else
`endif
                    begin
                        state_s     = RESP;
                        rsp_rdata_s = load_single_s;
                    end
                end else if (timeout_s) begin
                    state_s    = RESP;
                    rsp_trap_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ISSUE2: begin
                if (i_mem_ready) begin
                    state_s = we_r ? RESP : WAIT2;
                end else if (timeout_s) begin
                    state_s    = RESP;
                    rsp_trap_s = 1'b1;
                end else begin
                    state_s = ISSUE2;
                end
            end
            WAIT2: begin
                if (i_mem_rvalid) begin
                    state_s     = RESP;
                    rsp_rdata_s = load_split_s;
                end else if (timeout_s) begin
                    state_s    = RESP;
                    rsp_trap_s = 1'b1;
                end else begin
                    state_s = WAIT2;
                end
            end
`endif
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, timeout counter and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_WIDTH{1'b0}};
            o_req_ready <= 1'b1;
            o_mem_valid <= 1'b0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= 32'h00000000;
            o_mem_mask  <= 4'b0000;
            o_mem_wdata <= 32'h00000000;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h00000000;
            o_rsp_trap  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_clr_s ? {CNT_WIDTH{1'b0}} : (busy_s ? cnt_r + CNT_WIDTH'(1) : cnt_r);
            o_req_ready <= (state_s == IDLE);
`ifdef LSU_MISALIGNED_SPLIT_EN
            o_mem_valid <= (state_s == ISSUE) || (state_s == ISSUE2);
            o_mem_ren   <= ((state_s == ISSUE) || (state_s == ISSUE2)) && !we_s;
            o_mem_wen   <= ((state_s == ISSUE) || (state_s == ISSUE2)) && we_s;
`else
            o_mem_valid <= (state_s == ISSUE);
            o_mem_ren   <= (state_s == ISSUE) && !we_s;
            o_mem_wen   <= (state_s == ISSUE) && we_s;
`endif
            o_mem_addr  <= mem_addr_s;
            o_mem_mask  <= mem_mask_s;
            o_mem_wdata <= mem_wdata_s;
            o_rsp_valid <= (state_s == RESP);
            o_rsp_rdata <= rsp_rdata_s;
            o_rsp_trap  <= rsp_trap_s;
        end
    end

    // Request attributes held for the duration of the access
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_r   <= 1'b0;
            uns_r  <= 1'b0;
            size_r <= 2'b00;
            off_r  <= 2'b00;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_r    <= 1'b0;
            mask_hi_r  <= 4'b0000;
            wdata_hi_r <= 32'h00000000;
            rlo_r      <= 32'h00000000;
`endif
        end else begin
            if ((state_r == IDLE) && i_req_valid) begin
                we_r   <= i_req_we;
                uns_r  <= i_req_unsigned;
                size_r <= i_req_size;
                off_r  <= i_req_addr[1:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                split_r    <= split_s;
                mask_hi_r  <= mask_hi_s;
                wdata_hi_r <= wdata_hi_s;
`endif
            end else begin
                we_r <= we_r;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (capture_s) begin
                rlo_r <= i_mem_rdata;
            end else begin
                rlo_r <= rlo_r;
            end
`endif
        end
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Multi-cycle load/store unit between the hart's execute stage and a realistic data memory with variable latency.
- Successor to the hart's combinational dmem port. Generalised to valid/ready handshakes and variable read latency.
- Adds misalignment trapping, a response timeout, and optional split misaligned accesses.
- Performs byte-lane alignment, mask generation, and sign/zero extension internally, so the hart sees whole values.

Parameters:
- TIMEOUT_CYCLES, default 256: cycles allowed in ISSUE+WAIT before trapping. 0 disables the timeout.
- CNT_WIDTH, default 9: width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  hart request valid
- o_req_ready  out  1  unit idle, can accept a request
- i_req_we  in  1  1=store, 0=load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  zero-extend load result (lbu/lhu)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store value, right-justified
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  32  extended load data; 0 for stores and traps
- o_rsp_trap  out  1  misaligned, illegal size, or timeout
- o_mem_valid  out  1  memory request valid
- i_mem_ready  in  1  memory accepts request
- o_mem_addr  out  32  word-aligned address, [1:0]=00
- o_mem_ren  out  1  read request
- o_mem_wen  out  1  write request
- o_mem_mask  out  4  byte-lane enables
- o_mem_wdata  out  32  lane-shifted store data
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  32  read data word

Behaviour:
- All outputs are registered. Reset drives every output to 0, except o_req_ready=1. State goes to IDLE and the counter clears.
- Reset mid-operation abandons the access. A late i_mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: o_req_ready=1. A request is accepted when i_req_valid && o_req_ready (cycle N).
  - Legal request: ISSUE at N+1.
  - Illegal request: RESP at N+1 with trap=1, and no memory access occurs. Illegal means size 11, half with addr[0]=1, or word with addr[1:0]!=0.
- ISSUE: o_mem_valid=1, with ren=~we and wen=we. ren and wen are never both 1.
  - When i_mem_ready=1: a store goes to RESP, a load goes to WAIT.
  - Request fields are held stable until accepted.
- WAIT: hold until i_mem_rvalid=1, then capture data and go to RESP. i_mem_rvalid during ISSUE is ignored.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. There is no back-pressure on the response.
- Minimum latency:
  - Store: accept N → rsp N+2.
  - Load: accept N, ready N+1, rvalid N+2 → rsp N+3.
- Mask:
  - byte: 0001<<addr[1:0]
  - half: 0011<<(2*addr[1])
  - word: 1111
- Store data: wdata shifted left by 8*addr[1:0].
- Load data: rdata shifted right by 8*addr[1:0], then truncated to size. Sign-extended unless i_req_unsigned; i_req_unsigned is ignored for word.
- Timeout: the counter increments each cycle in ISSUE/WAIT and clears on accept. When it reaches TIMEOUT_CYCLES, go to RESP with trap=1 and rdata=0, and drop o_mem_valid.
- Back-to-back: a new request is accepted in the cycle after RESP.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- When defined, non-crossing misaligned accesses proceed as a single access. Example: half at offset 1 uses mask 0110.
- When defined, boundary-crossing accesses are split into two back-to-back transactions:
  - Crossing cases: half at offset 3, word at offset 1/2/3.
  - First access: addr&~3, upper lanes.
  - Second access: (addr&~3)+4, lower lanes.
  - Extra states ISSUE2/WAIT2. Load data is merged before extension.
  - A store performs both writes.
  - A timeout on either half sets trap. For stores, the first write is not undone.
  - Only size 11 traps.
- When undefined, all misaligned requests trap as described above, and ISSUE2/WAIT2 do not exist.

Test Plan:
- Reset, then idle with no stimulus → o_req_ready=1, all other outputs 0.
- lb at 0x1003, mem returns 0x80AABBCC with rvalid 1 cycle after ready:
  - o_mem_addr=0x1000, mask=1000
  - rsp at N+3 with rdata=0xFFFFFF80
  - same access as lbu → 0x00000080
- sh 0x0000BEEF at 0x2002 → mask=1100, wdata=0xBEEF0000, rsp N+2, trap=0.
- lw at 0x3001 (macro off) → rsp at N+1 with trap=1, o_mem_valid never asserted.
- lw at 0x4000 with rvalid withheld and TIMEOUT_CYCLES=8 → rsp trap=1 exactly 8 cycles after accept. A later rvalid in IDLE is ignored.
- Macro on, lw at 0x5002, words 0x11223344@0x5000 and 0x55667788@0x5004:
  - masks 1100 then 0011
  - rdata=0x77881122, trap=0
